axi_read_responder: RTL
=======================

# axi_read_responder

Slave-side AXI read responder: accepts one AR request at a time from the interconnect and returns the read burst on the R channel from a synchronous single-port SRAM. It is the read-data source for one slave port, and its RID/RDATA/RRESP/RLAST/RVALID outputs feed the interconnect's R-channel return path toward the master. Bursts are generated beat by beat with a burst counter and RLAST, and each beat is held stable under RREADY back-pressure.

## Interface
- ID_W, 8: slave-side ID width (master ID plus interconnect tag)
- ADDR_W, 32: AXI address width
- DATA_W, 32: data width; one beat is one word
- MEM_AW, 14: SRAM word-address width
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- ARID_S  in  ID_W  read request ID
- ARADDR_S  in  ADDR_W  byte address of first beat
- ARLEN_S  in  4  beats minus one (0..15)
- ARSIZE_S  in  3  beat size; only 3'b010 (4 bytes) is legal
- ARBURST_S  in  2  2'b00 FIXED, 2'b01 INCR; anything else is illegal
- ARVALID_S  in  1  request valid
- ARREADY_S  out  1  request accepted
- RID_S  out  ID_W  latched ARID_S
- RDATA_S  out  DATA_W  beat data
- RRESP_S  out  2  2'b00 OKAY, 2'b10 SLVERR
- RLAST_S  out  1  final beat of burst
- RVALID_S  out  1  beat valid
- RREADY_S  in  1  beat accepted
- mem_CS  out  1  SRAM chip select (read strobe)
- mem_A  out  MEM_AW  SRAM word address
- mem_DO  in  DATA_W  SRAM read data, valid exactly one cycle after the address cycle

## Operation
- FSM states: IDLE, FETCH, WAIT, DATA. Reset state is IDLE.
- IDLE:
  - ARREADY_S=1.
  - AR handshake (ARVALID_S&ARREADY_S) latches id, addr_w=ARADDR_S[MEM_AW+1:2], len, burst, and err; clears beat counter cnt; goes to FETCH.
  - err=1 when ARSIZE_S!=3'b010 or ARBURST_S is not in {00,01}.
- FETCH: mem_CS=1, mem_A=addr_w; go to WAIT. When err=1, mem_CS=0 (no SRAM access).
- WAIT: SRAM drives mem_DO. At the clock edge, rdata_q<=err?0:mem_DO. Go to DATA.
- DATA:
  - RVALID_S=1, RDATA_S=rdata_q, RID_S=id, RRESP_S=err?2'b10:2'b00, RLAST_S=(cnt==len).
  - On R handshake with RLAST_S=1: go to IDLE.
  - On R handshake with RLAST_S=0: cnt<=cnt+1; if INCR, addr_w<=addr_w+1 (MEM_AW-bit wrap, 16383->0); if FIXED, addr_w is unchanged; go to FETCH.
  - Without handshake: stay in DATA; all R outputs held stable.
- ADDR_W bits above MEM_AW+1 and ARADDR_S[1:0] are ignored; slave decode is done upstream.
- An illegal request still returns exactly len+1 beats, all SLVERR, RDATA_S=0, RLAST_S on the final beat.
- ARREADY_S=0 in every state except IDLE, so there is no request overlap or interleaving.

## Timing
- Reset (async assert, any state): state=IDLE, ARREADY_S=1, RVALID_S=0, RLAST_S=0, RID_S=0, RDATA_S=0, RRESP_S=0, mem_CS=0, mem_A=0, cnt=0. An in-flight burst is abandoned; no further beats are issued.
- AR handshake at edge k: FETCH in cycle k+1, WAIT in k+2, first RVALID_S in k+3.
- Each subsequent beat: R handshake at edge j gives next RVALID_S in cycle j+3. RVALID_S is low in FETCH and WAIT.
- Last-beat handshake at edge j: IDLE in cycle j+1, so ARREADY_S=1 in j+1. Back-to-back request minimum spacing is 4 cycles plus 3 per extra beat.
- ARVALID_S high outside IDLE is ignored until IDLE. The request must be held by the master; none are lost.
- Outputs derive from registers and the state register only. There is no combinational path from RREADY_S or ARVALID_S to any output.

## Test plan
- Single INCR beat: ARADDR_S=0x0000_0010, ARLEN_S=0, ARID_S=0x35, mem word 4=0xDEADBEEF, RREADY_S=1 -> mem_A=4 in FETCH; one beat RDATA_S=0xDEADBEEF, RID_S=0x35, RRESP_S=0, RLAST_S=1, RVALID_S at k+3; ARREADY_S=1 next cycle.
- INCR burst with back-pressure: ARADDR_S=0x20, ARLEN_S=3, words 8..11=0x11,0x22,0x33,0x44, RREADY_S low 2 cycles on beat 1 -> beats 0x11..0x44 in order, beat 1 held stable while stalled, RLAST_S only on the 4th beat.
- FIXED burst: ARBURST_S=00, ARADDR_S=0x40, ARLEN_S=2 -> mem_A=16 for all 3 fetches; 3 beats, RLAST_S on the 3rd.
- Illegal request: ARSIZE_S=3'b001, ARLEN_S=1 -> mem_CS never asserted; 2 beats RRESP_S=2'b10, RDATA_S=0, RLAST_S on the 2nd.
- Address wrap: ARADDR_S=0xFFFC, ARLEN_S=1, INCR -> mem_A=16383 then 0.
- Reset mid-burst: assert ARESET during beat 2 of an ARLEN_S=7 burst -> RVALID_S=0 and ARREADY_S=1 immediately; a new request after release returns correct data with a fresh cnt.

Source files
------------

// File: rtl/axi_read_responder.sv
// Slave-side AXI read responder: one AR request at a time, bursts read beat by beat
// from a synchronous single-port SRAM (one-cycle read latency) onto the R channel.
module axi_read_responder #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   ARID_S,
  input  logic [ADDR_W-1:0] ARADDR_S,
  input  logic [3:0]        ARLEN_S,
  input  logic [2:0]        ARSIZE_S,
  input  logic [1:0]        ARBURST_S,
  input  logic              ARVALID_S,
  output logic              ARREADY_S,
  output logic [ID_W-1:0]   RID_S,
  output logic [DATA_W-1:0] RDATA_S,
  output logic [1:0]        RRESP_S,
  output logic              RLAST_S,
  output logic              RVALID_S,
  input  logic              RREADY_S,
  output logic              mem_CS,
  output logic [MEM_AW-1:0] mem_A,
  input  logic [DATA_W-1:0] mem_DO
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DATA} state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     id;
  logic [MEM_AW-1:0]   addr_w;
  logic [3:0]          len;
  logic [3:0]          cnt;
  logic                incr;
  logic                err;
  logic [DATA_W-1:0]   rdata_q;
  logic                ar_hs;
  logic                r_hs;
  logic                last;

  // Address bits outside the SRAM word range are decoded upstream.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ARADDR_S[ADDR_W-1:MEM_AW+2], ARADDR_S[1:0]};

  assign ar_hs = (state == IDLE) && ARVALID_S;
  assign r_hs  = (state == DATA) && RREADY_S;
  assign last  = (cnt == len);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ARVALID_S) state_next = FETCH;
      FETCH:   state_next = WAIT;
      WAIT:    state_next = DATA;
      DATA:    if (RREADY_S) state_next = last ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      id      <= '0;
      addr_w  <= '0;
      len     <= '0;
      cnt     <= '0;
      incr    <= 1'b0;
      err     <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (ar_hs) begin
        id     <= ARID_S;
        addr_w <= ARADDR_S[MEM_AW+1:2];
        len    <= ARLEN_S;
        cnt    <= '0;
        incr   <= (ARBURST_S == 2'b01);
        err    <= (ARSIZE_S != 3'b010) || ARBURST_S[1];
      end
      // Capture the SRAM word once; it stays put while the master stalls.
      if (state == WAIT) rdata_q <= err ? '0 : mem_DO;
      if (r_hs && !last) begin
        cnt <= cnt + 4'd1;
        if (incr) addr_w <= addr_w + MEM_AW'(1);
      end
    end
  end

  assign ARREADY_S = (state == IDLE);
  assign RVALID_S  = (state == DATA);
  assign RLAST_S   = (state == DATA) && last;
  assign RID_S     = id;
  assign RDATA_S   = rdata_q;
  assign RRESP_S   = ((state == DATA) && err) ? 2'b10 : 2'b00;
  // Illegal requests never touch the SRAM.
  assign mem_CS    = (state == FETCH) && !err;
  assign mem_A     = addr_w;

endmodule
